// File: rtl/y_signature_compactor.sv
// y_signature_compactor
//   Compresses the wide y output bus of the fuzzed design into a single MISR
//   signature. This lets a netlist run and an RTL reference run be compared with
//   one word. Each accepted sample is folded into SIG_W bits by XOR-ing its
//   SIG_W-bit words, and the folded word is then clocked into the MISR.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active low
//   start       begin a run (accepted in IDLE or DONE, ignored in RUN)
//   y_valid     y carries a real sample this cycle
//   y           DATA_W-bit output bus of the design under observation
//   expected    golden signature, compared while in DONE
//   busy        high in RUN
//   done        high in DONE, held until start or reset
//   match       done && (signature == expected), registered
//   signature   current MISR state
//   sample_cnt  samples compacted in this run (saturates at 255)
module y_signature_compactor #(
  parameter int              DATA_W      = 1490,
  parameter int              SIG_W       = 32,
  parameter logic [SIG_W-1:0] POLY       = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED       = 32'h00000000,
  parameter int              NUM_SAMPLES = 20,
  parameter int              SKIP        = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              y_valid,
  input  logic [DATA_W-1:0] y,
  input  logic [SIG_W-1:0]  expected,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [SIG_W-1:0]  signature,
  output logic [7:0]        sample_cnt
);

  localparam int NW  = (DATA_W + SIG_W - 1) / SIG_W;   // folded words
  localparam int SKW = (SKIP < 1) ? 1 : $clog2(SKIP + 1);
  localparam logic [SKW-1:0] SKIP_V = SKW'(SKIP);
  localparam logic [8:0]     NS_V   = 9'(NUM_SAMPLES);

  generate
    if (NUM_SAMPLES < 1 || NUM_SAMPLES > 255) begin : g_bad_ns
      $error("y_signature_compactor: NUM_SAMPLES must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [SKW-1:0]   skip_q, skip_d;
  logic             match_q, match_d;

  // Fold: zero-extend y to NW whole words, then XOR-reduce word by word.
  logic [NW*SIG_W-1:0]       ypad;
  logic [NW:0][SIG_W-1:0]    acc;
  logic [SIG_W-1:0]          fold;
  logic [SIG_W-1:0]          misr_next;

  assign ypad   = (NW*SIG_W)'(y);
  assign acc[0] = '0;
  generate
    for (genvar w = 0; w < NW; w++) begin : g_fold
      assign acc[w+1] = acc[w] ^ ypad[w*SIG_W +: SIG_W];
    end
  endgenerate
  assign fold = acc[NW];

  assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                   ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ fold;

  // Next state. fold/misr_next are only consumed under y_valid, so an
  // undriven y between samples never reaches the signature.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          skip_d  = '0;
        end
      end
      RUN: begin
        if (y_valid) begin
          // skip_q never passes SKIP, so inequality marks the warm-up window
          if (skip_q != SKIP_V) begin
            skip_d = skip_q + 1'b1;
          end else begin
            sig_d = misr_next;
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            if (({1'b0, cnt_q} + 9'd1) == NS_V) state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // match is registered alongside the transition into DONE, so it is valid
  // on the same cycle done rises and keeps tracking expected while in DONE.
  always_comb begin
    match_d = (state_d == DONE) && (sig_d == expected);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      skip_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      match_q <= match_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign match      = match_q;
  assign signature  = sig_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_y_signature_compactor.sv
module tb_y_signature_compactor;

  localparam int DW = 1490;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  // Instances: 0 main (N=20), 1 single sample, 2 seed MSB set, 3 N=2, 4 SKIP=2
  localparam logic [4:0][31:0] SD = {32'h0, 32'h0, 32'h80000000, 32'h0, 32'h0};
  localparam logic [4:0][7:0]  NS = {8'd1, 8'd2, 8'd1, 8'd1, 8'd20};
  localparam logic [4:0][7:0]  SK = {8'd2, 8'd0, 8'd0, 8'd0, 8'd0};

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] start;
  logic y_valid;
  logic [DW-1:0] y;
  logic [31:0] expected;
  logic [4:0] busy, done, match;
  logic [4:0][31:0] sig;
  logic [4:0][7:0] cnt;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 5; g++) begin : g_dut
      y_signature_compactor #(
        .DATA_W(DW), .SIG_W(32), .POLY(POLY), .SEED(SD[g]),
        .NUM_SAMPLES(int'(NS[g])), .SKIP(int'(SK[g]))
      ) dut (
        .clk(clk), .rst_n(rst_n), .start(start[g]), .y_valid(y_valid),
        .y(y), .expected(expected), .busy(busy[g]), .done(done[g]),
        .match(match[g]), .signature(sig[g]), .sample_cnt(cnt[g])
      );
    end
  endgenerate

  typedef struct {
    logic [31:0] sig;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  logic [DW-1:0] stim[$];
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] fold_m(input logic [DW-1:0] v);
    logic [1503:0] p;
    logic [31:0] r;
    p = '0;
    p[DW-1:0] = v;
    r = '0;
    for (int i = 0; i < 47; i++) r = r ^ p[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [31:0] step_m(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  function automatic logic [31:0] model_sig(input logic [31:0] seed, input int skip);
    logic [31:0] s;
    s = seed;
    for (int i = skip; i < stim.size(); i++) s = step_m(s, fold_m(stim[i]));
    return s;
  endfunction

  function automatic logic [DW-1:0] rnd_y();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < 47; i++) v = {v[DW-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic push_exp(input int idx);
    exp_t e;
    e.sig = model_sig(SD[idx], int'(SK[idx]));
    e.cnt = 8'(stim.size() - int'(SK[idx]));
    sb.push_back(e);
  endtask

  // Drives every entry of stim as one valid sample, with gap idle cycles
  // (y undriven) between samples. Returns at the negedge after the last
  // sample edge.
  task automatic drive_run(input int idx, input bit do_start, input int gap);
    if (do_start) begin
      @(negedge clk); start[idx] = 1'b1;
      @(negedge clk); start[idx] = 1'b0;
    end
    for (int i = 0; i < stim.size(); i++) begin
      y_valid = 1'b1; y = stim[i];
      @(negedge clk);
      if (gap > 0 && i != stim.size() - 1) begin
        y_valid = 1'b0; y = 'x;
        repeat (gap) @(negedge clk);
      end
    end
    y_valid = 1'b0; y = 'x;
  endtask

  task automatic check_done(input int idx, input string nm);
    int w;
    exp_t e;
    w = 0;
    while (done[idx] !== 1'b1 && w < 50) begin
      @(negedge clk); w++;
    end
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL %s done_latency: waited %0d cycles, required 0", nm, w);
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: empty queue, required 1 entry", nm);
    end else begin
      e = sb.pop_front();
      checks++;
      if (sig[idx] !== e.sig) begin
        errors++;
        $display("FAIL %s signature: got %h, required %h", nm, sig[idx], e.sig);
      end
      checks++;
      if (cnt[idx] !== e.cnt) begin
        errors++;
        $display("FAIL %s sample_cnt: got %0d, required %0d", nm, cnt[idx], e.cnt);
      end
      checks++;
      if (busy[idx] !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_in_done: got %b, required 0", nm, busy[idx]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = '0; y_valid = 1'b0; y = '0; expected = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({busy[i], done[i], match[i]} !== 3'b000 || sig[i] !== SD[i] || cnt[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset[%0d]: got busy/done/match=%b%b%b sig=%h cnt=%0d, required 000 %h 0",
                 i, busy[i], done[i], match[i], sig[i], cnt[i], SD[i]);
      end
    end
  endtask

  task automatic test_zeros();
    logic [31:0] s0;
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back('0);
    push_exp(0);
    drive_run(0, 1'b1, 0);
    check_done(0, "zeros20");
    s0 = sig[0];
    // DONE ignores further valid samples
    repeat (3) begin
      y_valid = 1'b1; y = rnd_y(); @(negedge clk);
    end
    y_valid = 1'b0;
    checks++;
    if (sig[0] !== s0 || cnt[0] !== 8'd20 || done[0] !== 1'b1) begin
      errors++;
      $display("FAIL done_frozen: got sig=%h cnt=%0d done=%b, required %h 20 1", sig[0], cnt[0], done[0], s0);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] v;
    stim.delete(); v = '0; v[0] = 1'b1; stim.push_back(v);
    push_exp(1);
    drive_run(1, 1'b1, 0);
    check_done(1, "y_is_1");
    stim.delete(); v = '0; v[32] = 1'b1; stim.push_back(v);
    push_exp(1);
    drive_run(1, 1'b1, 0);
    check_done(1, "fold_alias");
    // top partial word: bit 1489 lands in word 46 bit 17
    stim.delete(); v = '0; v[DW-1] = 1'b1; stim.push_back(v);
    push_exp(1);
    drive_run(1, 1'b1, 0);
    check_done(1, "top_bit");
  endtask

  task automatic test_poly_match();
    expected = 32'h04C11DB7;
    stim.delete(); stim.push_back('0);
    push_exp(2);
    drive_run(2, 1'b1, 0);
    check_done(2, "poly");
    checks++;
    if (match[2] !== 1'b1) begin
      errors++;
      $display("FAIL match_hit: got %b, required 1", match[2]);
    end
    expected = 32'h04C11DB6;
    @(negedge clk);
    checks++;
    if (match[2] !== 1'b0) begin
      errors++;
      $display("FAIL match_miss: got %b, required 0", match[2]);
    end
    expected = '0;
  endtask

  task automatic test_gap();
    logic [DW-1:0] v;
    stim.delete(); v = '0; v[0] = 1'b1; stim.push_back(v); stim.push_back('0);
    push_exp(3);
    @(negedge clk); start[3] = 1'b1;
    @(negedge clk); start[3] = 1'b0;
    y_valid = 1'b1; y = stim[0]; @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      y_valid = 1'b0; y = 'x; @(negedge clk);
      checks++;
      if (busy[3] !== 1'b1 || sig[3] !== 32'h1 || cnt[3] !== 8'd1) begin
        errors++;
        $display("FAIL gap_hold[%0d]: got busy=%b sig=%h cnt=%0d, required 1 00000001 1", i, busy[3], sig[3], cnt[3]);
      end
    end
    y_valid = 1'b1; y = stim[1]; @(negedge clk);
    y_valid = 1'b0; y = 'x;
    check_done(3, "gap2");
  endtask

  task automatic test_skip();
    logic [DW-1:0] ones;
    ones = '1;
    stim.delete(); stim.push_back(ones); stim.push_back(ones); stim.push_back('0);
    push_exp(4);
    drive_run(4, 1'b1, 1);
    check_done(4, "skip2");
  endtask

  task automatic test_reset_midrun();
    logic [31:0] m;
    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(rnd_y());
    drive_run(0, 1'b1, 0);
    m = model_sig(SD[0], 0);
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    checks++;
    if (sig[0] !== m || cnt[0] !== 8'd5 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run: got sig=%h cnt=%0d busy=%b, required %h 5 1", sig[0], cnt[0], busy[0], m);
    end
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    checks++;
    if (sig[0] !== SD[0] || cnt[0] !== 8'd0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: got sig=%h cnt=%0d busy=%b done=%b, required %h 0 0 0", sig[0], cnt[0], busy[0], done[0], SD[0]);
    end
  endtask

  task automatic test_back_to_back();
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(rnd_y());
    push_exp(0);
    drive_run(0, 1'b1, 1);
    check_done(0, "random_gapped");
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b1 || sig[0] !== SD[0] || cnt[0] !== 8'd0) begin
      errors++;
      $display("FAIL restart: got done=%b busy=%b sig=%h cnt=%0d, required 0 1 %h 0", done[0], busy[0], sig[0], cnt[0], SD[0]);
    end
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(rnd_y());
    push_exp(0);
    drive_run(0, 1'b0, 0);
    check_done(0, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_single();
    test_poly_match();
    test_gap();
    test_skip();
    test_reset_midrun();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
